rffp_fp_enc_pipe: RTL and testbench
===================================

RFFP_FP_ENC_PIPE -- requirements
Module: rffp_fp_enc_pipe

Interface
REQ-001 Parameter EXP_WIDTH, default 8: FP (bfloat16) exponent width.
REQ-002 Parameter MAN_WIDTH, default 7: FP stored mantissa width.
REQ-003 Parameter RFFP_EXP, default 6: RFFP exponent width.
REQ-004 Parameter RFFP_MAN_WIDTH, default 8: RFFP mantissa width, leading one explicit in bit 7.
REQ-005 Parameter EXP_OFFSET, default 76: FP exponent minus RFFP exponent for normalized values.
REQ-006 Port clk, input, 1: the single clock; all state on rising edge.
REQ-007 Port rst, input, 1: reset, asynchronous and active-high.
REQ-008 Port in_fp, input, 16: bfloat16 {sign, exp[7:0], man[6:0]}.
REQ-009 Port in_valid / in_ready, input / output, 1 each: upstream handshake.
REQ-010 Port out_rffp, output, 15: RFFP {sign, exp[5:0], man[7:0]}, the same layout the RFFP-to-FP decoder consumes.
REQ-011 Port out_sat / out_flush, output, 1 each: flags qualified by out_valid.
REQ-012 Port out_valid / out_ready, output / input, 1 each: downstream handshake.
REQ-013 Port cnt_clr, input, 1: synchronous clear of both event counters.
REQ-014 Port sat_count / flush_count, output, 16 each: event counters.

Function
REQ-015 Transfer occurs on a cycle with valid and ready both high; payload sampled only then.
REQ-016 Two register stages S1 (classify) and S2 (pack); latency in_valid&in_ready to out_valid is exactly 2 cycles with out_ready held high.
REQ-017 S2 loads when !s2_valid or out_ready; S1 loads when !s1_valid or S2 loads; in_ready equals S1 load condition (combinational path from out_ready allowed).
REQ-018 Full throughput: one item per cycle sustained while out_ready is high; no bubbles inserted.
REQ-019 out_rffp, out_sat and out_flush hold stable while out_valid high and out_ready low.
REQ-020 Classification from e8 = in_fp[14:7]: ZERO if e8==0; FLUSH if 1<=e8<=76; NORMAL if 77<=e8<=139; SAT if e8>=140, including 255 (Inf/NaN).
REQ-021 NORMAL: out exp = e8-76 (range 1..63), out man = {1'b1, in_fp[6:0]}, exact, no rounding.
REQ-022 ZERO and FLUSH: out exp = 0, out man = 0, sign preserved; out_flush=1 only for FLUSH.
REQ-023 SAT: out exp = 63, out man = 8'hFF, sign preserved (NaN sign taken as-is); out_sat=1.
REQ-024 Sign bit of out_rffp always equals in_fp[15].
REQ-025 sat_count / flush_count increment by 1 on each output transfer carrying out_sat / out_flush respectively; saturate at 16'hFFFF, no wrap.
REQ-026 cnt_clr high clears both counters next edge; cnt_clr wins over a coincident increment.
REQ-027 Counters unaffected by items still in flight or stalled.

Reset
REQ-028 rst asserted: s1_valid, s2_valid, out_valid, out_sat, out_flush go 0 immediately; out_rffp 0; counters 0.
REQ-029 in_ready is 1 in the first cycle after rst deasserts; items in flight at reset are discarded, not counted.

Verification
REQ-030 Send 0x3F80 (1.0), out_ready=1 -> out_rffp 0x3380 two cycles later, flags 0.
REQ-031 Send 0xC020 (-2.5) -> 0x74A0; send 0x4600 (e8=140) -> 0x3FFF, out_sat=1, sat_count=1; send 0x4580 (e8=139) -> 0x3F80, no flag.
REQ-032 Send 0x2600 (e8=76) -> 0x0000, out_flush=1, flush_count=1; send 0x8000 -> 0x4000, no flag, counts unchanged; send 0x2680 (e8=77) -> 0x0180.
REQ-033 Stream 8 items with out_ready low for cycles 3-6 -> in_ready drops after 2 accepts, no loss/duplication, order preserved, output stable during stall.
REQ-034 Drive 0xFFFF sat items into a counter preloaded at 0xFFFE -> sat_count sticks at 0xFFFF; pulse cnt_clr during a sat transfer -> 0.
REQ-035 Assert rst mid-stream with both stages full -> out_valid 0 asynchronously, counters 0, next accepted item emerges after exactly 2 cycles.

Source files
------------

// File: rtl/rffp_fp_enc_pipe.sv
// rffp_fp_enc_pipe: two-stage bfloat16 to RFFP encoder with flush/saturate flags and event counters
module rffp_fp_enc_pipe #(
  parameter int EXP_WIDTH      = 8,
  parameter int MAN_WIDTH      = 7,
  parameter int RFFP_EXP       = 6,
  parameter int RFFP_MAN_WIDTH = 8,
  parameter int EXP_OFFSET     = 76
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [EXP_WIDTH+MAN_WIDTH:0]     in_fp,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [RFFP_EXP+RFFP_MAN_WIDTH:0] out_rffp,
  output logic                             out_sat,
  output logic                             out_flush,
  output logic                             out_valid,
  input  logic                             out_ready,
  input  logic                             cnt_clr,
  output logic [15:0]                      sat_count,
  output logic [15:0]                      flush_count
);
  localparam int EXP_MAX = EXP_OFFSET + (1 << RFFP_EXP) - 1;
  typedef enum logic [1:0] {ZERO, FLUSH, NORM, SAT} cls_t;
  logic [EXP_WIDTH-1:0] e8;
  cls_t cls, s1_cls;
  logic s1_valid, s1_sign, s1_load, s2_load, fire;
  logic [RFFP_EXP-1:0] s1_exp, pk_exp;
  logic [MAN_WIDTH-1:0] s1_man;
  logic [RFFP_MAN_WIDTH-1:0] pk_man;
  assign e8 = in_fp[EXP_WIDTH+MAN_WIDTH-1:MAN_WIDTH];
  assign s2_load = !out_valid || out_ready;
  assign s1_load = !s1_valid || s2_load;
  assign in_ready = s1_load;
  assign fire = out_valid && out_ready;
  always_comb begin
    cls = (e8 == '0) ? ZERO : (32'(e8) <= EXP_OFFSET) ? FLUSH : (32'(e8) <= EXP_MAX) ? NORM : SAT;
    pk_exp = (s1_cls == SAT) ? '1 : (s1_cls == NORM) ? s1_exp : '0;
    pk_man = (s1_cls == SAT) ? '1 : (s1_cls == NORM) ? RFFP_MAN_WIDTH'({1'b1, s1_man}) : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_cls   <= ZERO;
      s1_exp   <= '0;
      s1_man   <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= in_fp[EXP_WIDTH+MAN_WIDTH];
        s1_cls  <= cls;
        s1_exp  <= RFFP_EXP'(e8 - EXP_WIDTH'(EXP_OFFSET));
        s1_man  <= in_fp[MAN_WIDTH-1:0];
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_rffp  <= '0;
      out_sat   <= 1'b0;
      out_flush <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_rffp  <= {s1_sign, pk_exp, pk_man};
        out_sat   <= s1_cls == SAT;
        out_flush <= s1_cls == FLUSH;
      end
    end
  end
  // counters saturate at all-ones; clear beats a coincident increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_count   <= '0;
      flush_count <= '0;
    end else begin
      sat_count   <= cnt_clr ? '0 : (fire && out_sat && !(&sat_count)) ? sat_count + 16'd1 : sat_count;
      flush_count <= cnt_clr ? '0 : (fire && out_flush && !(&flush_count)) ? flush_count + 16'd1 : flush_count;
    end
  end
endmodule

// File: tb/tb_rffp_fp_enc_pipe.sv
// tb_rffp_fp_enc_pipe: scoreboard bench for the bfloat16 to RFFP encoder pipeline
module tb_rffp_fp_enc_pipe;
  logic clk = 0, rst = 1;
  logic [15:0] in_fp = '0;
  logic in_valid = 0, in_ready;
  logic [14:0] out_rffp;
  logic out_sat, out_flush, out_valid;
  logic out_ready = 1, cnt_clr = 0;
  logic [15:0] sat_count, flush_count;
  typedef struct {logic [16:0] v; int t; bit lat;} ent_t;
  ent_t sb[$];
  ent_t e;
  int n_chk = 0, n_pass = 0, cyc = 0, acc_cnt = 0, base = 0;
  int m_sat = 0, m_flush = 0;
  bit lat_mode = 1, hold_v = 0, done = 0;
  logic [16:0] hold;
  logic [15:0] items [8] = '{16'h3F80, 16'h0100, 16'h7F80, 16'hBC00, 16'h2680, 16'h4600, 16'h8000, 16'hC580};
  rffp_fp_enc_pipe dut (
    .clk(clk), .rst(rst), .in_fp(in_fp), .in_valid(in_valid), .in_ready(in_ready),
    .out_rffp(out_rffp), .out_sat(out_sat), .out_flush(out_flush), .out_valid(out_valid),
    .out_ready(out_ready), .cnt_clr(cnt_clr), .sat_count(sat_count), .flush_count(flush_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  // reference encoder: {sat, flush, rffp[14:0]}
  function automatic logic [16:0] enc(input logic [15:0] x);
    int ex = int'(x[14:7]);
    logic [5:0] oe = 6'(ex - 76);
    if (ex == 0) return {2'b00, x[15], 14'h0};
    if (ex <= 76) return {2'b01, x[15], 14'h0};
    if (ex >= 140) return {2'b10, x[15], 14'h3FFF};
    return {2'b00, x[15], oe, 1'b1, x[6:0]};
  endfunction
  task automatic send(input logic [15:0] x, input logic [16:0] ev);
    bit acc = 0;
    in_fp = x;
    in_valid = 1;
    for (int n = 0; n < 200 && !acc; n++) begin
      #1 acc = in_ready;
      if (acc) begin
        sb.push_back('{ev, cyc, lat_mode});
        acc_cnt++;
      end
      @(negedge clk);
    end
    if (!acc) chk("accept_timeout", 0, 1);
    in_valid = 0;
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      #3 n++;
    end
    chk("drain", sb.size(), 0);
    @(negedge clk);
  endtask
  always begin
    @(negedge clk);
    #2;
    if (!rst) begin
      chk("sat_count", sat_count, m_sat);
      chk("flush_count", flush_count, m_flush);
      if (hold_v) chk("hold", {out_valid, out_sat, out_flush, out_rffp}, {1'b1, hold});
      hold_v = out_valid && !out_ready;
      hold = {out_sat, out_flush, out_rffp};
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("spurious_out", 1, 0);
        else begin
          e = sb.pop_front();
          chk("out", {out_sat, out_flush, out_rffp}, e.v);
          if (e.lat) chk("latency", cyc - e.t, 2);
          if (e.v[16] && m_sat < 65535) m_sat++;
          if (e.v[15] && m_flush < 65535) m_flush++;
        end
      end
      if (cnt_clr) begin
        m_sat = 0;
        m_flush = 0;
      end
    end else hold_v = 0;
  end
  initial begin
    repeat (2) @(negedge clk);
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_rffp", out_rffp, 0);
    chk("rst_flags", {out_sat, out_flush}, 0);
    chk("rst_counts", {sat_count, flush_count}, 0);
    @(negedge clk);
    rst = 0;
    #1 chk("rdy_after_rst", in_ready, 1);
    @(negedge clk);
    send(16'h3F80, 17'h03380);
    send(16'hC020, 17'h074A0);
    send(16'h4600, 17'h13FFF);
    send(16'h4580, 17'h03F80);
    drain();
    #3 chk("sat_cnt_1", sat_count, 1);
    chk("flush_cnt_0", flush_count, 0);
    send(16'h2600, 17'h08000);
    send(16'h8000, 17'h04000);
    send(16'h2680, 17'h00180);
    drain();
    #3 chk("sat_cnt_1b", sat_count, 1);
    chk("flush_cnt_1", flush_count, 1);
    @(negedge clk);
    lat_mode = 0;
    base = acc_cnt;
    fork
      for (int i = 0; i < 8; i++) send(items[i], enc(items[i]));
      begin
        out_ready = 0;
        repeat (4) @(negedge clk);
        chk("stall_accepts", acc_cnt - base, 2);
        chk("stall_ready", in_ready, 0);
        out_ready = 1;
      end
    join
    drain();
    chk("stall_total", acc_cnt - base, 8);
    done = 0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          logic [15:0] r;
          r = 16'($urandom);
          send(r, enc(r));
        end
        done = 1;
      end
      while (!done) begin
        @(negedge clk);
        out_ready = 1'($urandom_range(0, 1));
      end
    join
    out_ready = 1;
    drain();
    lat_mode = 1;
    @(negedge clk);
    cnt_clr = 1;
    @(negedge clk);
    cnt_clr = 0;
    for (int i = 0; i < 65534; i++) send(16'hFFFF, 17'h17FFF);
    drain();
    #3 chk("sat_cnt_fffe", sat_count, 16'hFFFE);
    for (int i = 0; i < 3; i++) send(16'hFFFF, 17'h17FFF);
    drain();
    #3 chk("sat_cnt_stick", sat_count, 16'hFFFF);
    @(negedge clk);
    send(16'hFFFF, 17'h17FFF);
    @(negedge clk);
    #1 chk("clr_xfer", {out_valid, out_sat}, 2'b11);
    cnt_clr = 1;
    @(negedge clk);
    cnt_clr = 0;
    #3 chk("sat_cnt_clr", sat_count, 0);
    drain();
    lat_mode = 0;
    out_ready = 0;
    send(16'h4600, 17'h13FFF);
    send(16'h2600, 17'h08000);
    #1 chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_ready", in_ready, 0);
    #2 rst = 1;
    hold_v = 0;
    #1 chk("async_rst_valid", out_valid, 0);
    chk("async_rst_data", {out_sat, out_flush, out_rffp}, 0);
    chk("async_rst_counts", {sat_count, flush_count}, 0);
    sb.delete();
    m_sat = 0;
    m_flush = 0;
    @(negedge clk);
    rst = 0;
    out_ready = 1;
    lat_mode = 1;
    #1 chk("rdy_after_rst2", in_ready, 1);
    send(16'hC020, 17'h074A0);
    drain();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
